mdu_sched: RTL and testbench

Multiply/divide scheduler for the five-stage pipeline. Accepts MDU operations from the E stage, models the fixed multi-cycle latency of mult/div, owns the HI/LO registers, and raises the D-stage stall whenever an MDU-related instruction would collide with a busy unit. Its E-stage read data is the value carried into the M/W pipeline registers as the MDU result.

---
 rtl/mdu_pkg.sv | 43 ++++
 rtl/mdu_arith.sv | 73 +++++++
 rtl/mdu_sched.sv | 153 +++++++++++++++
 tb/tb_mdu_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: MDU opcodes, default latencies, scheduler state.
// Shared by mdu_arith and mdu_sched.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wr;
    } mdu_pend_t;

    function automatic int mdu_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 32x32 multiply / divide.
// Signed divide works on magnitudes, so INT_MIN/-1 wraps cleanly.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] ax;
    logic [63:0] bx;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q;
    logic [31:0] r;
    logic        sgn;

    // Select product or quotient/remainder for the requested op
    always_comb begin
        ax       = '0;
        bx       = '0;
        prod     = '0;
        a_mag    = '0;
        b_mag    = '0;
        q        = '0;
        r        = '0;
        sgn      = 1'b0;
        res_hi   = '0;
        res_lo   = '0;
        div_zero = is_div(op) && (b == 32'd0);
        unique case (1'b1)
            op == MDU_MULT: begin
                ax   = {{32{a[31]}}, a};
                bx   = {{32{b[31]}}, b};
                prod = ax * bx;
                {res_hi, res_lo} = prod;
            end
            op == MDU_MULTU: begin
                ax   = {32'd0, a};
                bx   = {32'd0, b};
                prod = ax * bx;
                {res_hi, res_lo} = prod;
            end
            op == MDU_DIV: begin
                a_mag = a[31] ? (32'd0 - a) : a;
                b_mag = b[31] ? (32'd0 - b) : b;
                sgn   = a[31] ^ b[31];
                if (b_mag != 32'd0) begin
                    q = a_mag / b_mag;
                    r = a_mag % b_mag;
                end
                res_lo = sgn   ? (32'd0 - q) : q;
                res_hi = a[31] ? (32'd0 - r) : r;
            end
            op == MDU_DIVU: begin
                if (b != 32'd0) begin
                    res_lo = a / b;
                    res_hi = a % b;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle MDU scheduler, owns HI/LO, D-stage stall.
// Optional MDU_CANCEL_EN adds a cancel port that aborts an op.
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [3:0]  E_op,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_md_use,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic        stall,
    output logic [31:0] E_MDUout,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CMAX = mdu_max(MULT_CYCLES, DIV_CYCLES);
    localparam int CW   = $clog2(CMAX + 1);

    mdu_state_e  state;
    mdu_state_e  state_n;
    logic [CW-1:0] cnt;
    mdu_pend_t   pend;
    logic        start;
    logic        commit;
    logic        abort;
    logic        cancel_i;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] ar_hi;
    logic [31:0] ar_lo;
    logic        ar_dz;

`ifdef MDU_CANCEL_EN
    assign cancel_i = cancel;
`else
    assign cancel_i = 1'b0;
`endif

    mdu_arith u_arith (
        .op       (E_op),
        .a        (E_rs),
        .b        (E_rt),
        .res_hi   (ar_hi),
        .res_lo   (ar_lo),
        .div_zero (ar_dz)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, start/commit/abort decisions, MT writes
    always_comb begin
        state_n = state;
        start   = 1'b0;
        commit  = 1'b0;
        abort   = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                mt_hi = (E_op == MDU_MTHI);
                mt_lo = (E_op == MDU_MTLO);
                if (E_start && (is_mul(E_op) || is_div(E_op))
                    && !cancel_i) begin
                    start   = 1'b1;
                    state_n = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cancel_i) begin
                    abort   = 1'b1;
                    state_n = ST_IDLE;
                end else if (cnt == CW'(1)) begin
                    commit  = pend.wr;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Counter and pending result
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            pend <= '0;
        end else if (start) begin
            cnt     <= is_mul(E_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            pend.hi <= ar_hi;
            pend.lo <= ar_lo;
            pend.wr <= !ar_dz;
        end else if (abort) begin
            cnt <= '0;
        end else if (state == ST_BUSY) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Architectural HI/LO: commit or move-to
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= pend.hi;
            lo <= pend.lo;
        end else begin
            if (mt_hi) hi <= E_rs;
            if (mt_lo) lo <= E_rs;
        end
    end

    assign busy  = (state == ST_BUSY);
    assign stall = D_md_use & (E_start | busy);

    // Move-from read path
    always_comb begin
        E_MDUout = '0;
        unique case (1'b1)
            E_op == MDU_MFHI: E_MDUout = hi;
            E_op == MDU_MFLO: E_MDUout = lo;
            default:          E_MDUout = '0;
        endcase
    end

`ifndef SYNTHESIS
    a_start_busy: assert property (
        @(posedge clk) disable iff (reset) busy |-> !E_start
    ) else $error("mdu_sched: E_start while busy");

    a_mt_busy: assert property (
        @(posedge clk) disable iff (reset)
        busy |-> !((E_op == MDU_MTHI) || (E_op == MDU_MTLO))
    ) else $error("mdu_sched: MTHI/MTLO while busy");
`endif

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: directed plan plus random ops vs a cycle-event model.
// Build with MDU_CANCEL_EN to also exercise the cancel path.
module tb_mdu_sched;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MDU_CANCEL_EN
    localparam bit CAN = 1'b1;
`else
    localparam bit CAN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        E_start;
    logic [3:0]  E_op;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
    logic        D_md_use;
    logic        cancel;
    logic        busy;
    logic        stall;
    logic [31:0] E_MDUout;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_start  (E_start),
        .E_op     (E_op),
        .E_rs     (E_rs),
        .E_rt     (E_rt),
        .D_md_use (D_md_use),
`ifdef MDU_CANCEL_EN
        .cancel   (cancel),
`endif
        .busy     (busy),
        .stall    (stall),
        .E_MDUout (E_MDUout),
        .hi       (hi),
        .lo       (lo)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int busy_cnt;
    int stall_cnt;

    bit          m_fl = 1'b0;
    int          m_end = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    bit          p_ok = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h",
                     tag, cyc, got, exp);
        end
    endtask

    // {ok, hi, lo} straight from the arithmetic definition
    function automatic logic [64:0] ref_res(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint rm;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (op)
            MDU_MULT:  r = 64'(sa * sb);
            MDU_MULTU: r = ua * ub;
            MDU_DIV: begin
                if (b == 0) return {1'b0, 64'd0};
                q  = sa / sb;
                rm = sa % sb;
                r  = {rm[31:0], q[31:0]};
            end
            MDU_DIVU: begin
                if (b == 0) return {1'b0, 64'd0};
                r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return {1'b1, r};
    endfunction

    task automatic set_in(input logic st, input logic [3:0] op,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic dmu);
        reset    = 1'b0;
        cancel   = 1'b0;
        E_start  = st;
        E_op     = op;
        E_rs     = rs;
        E_rt     = rt;
        D_md_use = dmu;
    endtask

    // Check outputs for the current cycle, clock, then advance the model
    task automatic cycle();
        logic [31:0] exp_out;
        logic [64:0] rr;
        #2;
        if (busy) busy_cnt++;
        if (stall) stall_cnt++;
        exp_out = (E_op == MDU_MFHI) ? m_hi :
                  (E_op == MDU_MFLO) ? m_lo : 32'd0;
        chk("busy", 32'(busy), 32'(m_fl));
        chk("stall", 32'(stall), 32'(D_md_use & (E_start | m_fl)));
        chk("mduout", E_MDUout, exp_out);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        @(posedge clk);
        if (reset) begin
            m_fl = 1'b0;
            m_hi = '0;
            m_lo = '0;
        end else if (m_fl) begin
            if (CAN && cancel) begin
                m_fl = 1'b0;
            end else if (cyc == m_end) begin
                if (p_ok) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
                m_fl = 1'b0;
            end
        end else begin
            if (E_start && !(CAN && cancel)) begin
                rr    = ref_res(E_op, E_rs, E_rt);
                p_ok  = rr[64];
                p_hi  = rr[63:32];
                p_lo  = rr[31:0];
                m_end = cyc + (((E_op == MDU_MULT) ||
                                (E_op == MDU_MULTU)) ? MC : DC);
                m_fl  = 1'b1;
            end
            if (E_op == MDU_MTHI) m_hi = E_rs;
            if (E_op == MDU_MTLO) m_lo = E_rs;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b0);
            cycle();
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'(2 + $urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        set_in(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_out", E_MDUout, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        busy_cnt = 0;
        set_in(1'b1, MDU_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        cycle();
        idle(MC + 1);
        chk("mult_busy_n", 32'(busy_cnt), 32'(MC));
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        set_in(1'b1, MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        cycle();
        idle(MC + 1);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        set_in(1'b1, MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        cycle();
        idle(DC + 1);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        set_in(1'b0, MDU_MTHI, 32'h11, 32'd0, 1'b0);
        cycle();
        set_in(1'b0, MDU_MTLO, 32'h22, 32'd0, 1'b0);
        cycle();
        busy_cnt = 0;
        set_in(1'b1, MDU_DIVU, 32'd7, 32'd0, 1'b0);
        cycle();
        idle(DC + 1);
        chk("dz_busy_n", 32'(busy_cnt), 32'(DC));
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);

        stall_cnt = 0;
        set_in(1'b1, MDU_MULT, 32'd3, 32'd4, 1'b1);
        cycle();
        for (int i = 0; i < MC; i++) begin
            set_in(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b1);
            cycle();
        end
        set_in(1'b0, MDU_MFLO, 32'd0, 32'd0, 1'b0);
        #2;
        chk("mflo_read", E_MDUout, 32'd12);
        cycle();
        chk("stall_n", 32'(stall_cnt), 32'(MC + 1));

        set_in(1'b0, MDU_MTHI, 32'h1234, 32'd0, 1'b1);
        #2;
        chk("mthi_stall", 32'(stall), 32'd0);
        cycle();
        set_in(1'b0, MDU_MFHI, 32'd0, 32'd0, 1'b0);
        #2;
        chk("mfhi_read", E_MDUout, 32'h1234);
        cycle();

        set_in(1'b1, MDU_DIV, 32'd100, 32'd7, 1'b0);
        cycle();
        idle(2);
        set_in(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        cycle();
        #2;
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_hi", hi, 32'd0);
        chk("rmid_lo", lo, 32'd0);
        idle(DC + 2);
        chk("rmid_late_lo", lo, 32'd0);

`ifdef MDU_CANCEL_EN
        set_in(1'b0, MDU_MTHI, 32'h5, 32'd0, 1'b0);
        cycle();
        set_in(1'b0, MDU_MTLO, 32'h6, 32'd0, 1'b0);
        cycle();
        set_in(1'b1, MDU_MULT, 32'd7, 32'd9, 1'b0);
        cycle();
        idle(1);
        set_in(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b0);
        cancel = 1'b1;
        cycle();
        #2;
        chk("can_busy", 32'(busy), 32'd0);
        idle(MC + 1);
        chk("can_hi", hi, 32'h5);
        chk("can_lo", lo, 32'h6);
        set_in(1'b1, MDU_DIV, 32'd9, 32'd3, 1'b0);
        cancel = 1'b1;
        cycle();
        #2;
        chk("can_start", 32'(busy), 32'd0);
        idle(1);
`endif

        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [3:0] op;
            r = $urandom_range(0, 9);
            if (m_fl) begin
                op = (r < 3) ? MDU_MFHI : (r < 6) ? MDU_MFLO : MDU_NONE;
                set_in(1'b0, op, $urandom, $urandom, 1'($urandom));
            end else if (r < 4) begin
                op = 4'(1 + $urandom_range(0, 3));
                set_in(1'b1, op, rnd_opnd(), rnd_opnd(), 1'($urandom));
            end else begin
                op = (r == 4) ? MDU_MTHI : (r == 5) ? MDU_MTLO :
                     (r == 6) ? MDU_MFHI : (r == 7) ? MDU_MFLO : MDU_NONE;
                set_in(1'b0, op, $urandom, $urandom, 1'($urandom));
            end
            if (CAN && ($urandom_range(0, 29) == 0)) cancel = 1'b1;
            if ($urandom_range(0, 299) == 0) reset = 1'b1;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
